pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default `IM_ADDR_BIT, the PC width.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- core_en  in  1  global advance enable.
- id_rs, id_rt  in  5 each  ID source registers.
- id_rs_used, id_rt_used  in  1 each  ID source really read.
- ex_rd  in  5  EX destination register.
- ex_is_load  in  1  EX holds a load.
- ex_branch_taken  in  1  EX redirects the PC.
- wb_halt  in  1  halt reached WB.
- resume  in  1  leave HALTED.
- irq_req  in  1  level interrupt request.
- id_valid  in  1  ID holds a real instruction.
- id_pc, if_pc  in  ADDR_W  PCs in ID and IF.
- pc_en  out  1  PC register load.
- pc_sel  out  2  0=seq, 1=branch, 2=vector.
- if_id_en, if_id_stall, if_id_clr_n  out  1 each  IF/ID controls; clr_n active-low.
- id_ex_en, id_ex_clr_n, ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n  out  1 each  per-stage enable and active-low clear.
- irq_ack  out  1  vector taken.
- epc  out  ADDR_W  saved return PC.
- halted  out  1  in HALTED.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-003 SHALL implement FSM states RUN, INT_DRAIN, INT_VECTOR, HALTED; control outputs are combinational from state and inputs; epc, counters, drain counter, state are registers.
REQ-004 Defaults, all states: every *_clr_n=1, if_id_stall=0, pc_sel=0, irq_ack=0; every *_en and pc_en = core_en.
REQ-005 core_en=0 SHALL freeze the FSM, drain counter, epc and counters.
REQ-006 Load-use hazard: ex_is_load & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
REQ-007 RUN, priority 1, ex_branch_taken=1: pc_sel=1, if_id_clr_n=0, id_ex_clr_n=0; hazard ignored; flush_cnt+1.
REQ-008 RUN, priority 2, hazard: pc_en=0, if_id_stall=1, id_ex_clr_n=0; stall_cnt+1; exactly one bubble per hazard.
REQ-009 RUN, priority 3, irq_req=1 with no branch (hazard irrelevant): if_id_clr_n=0, id_ex_clr_n=0, pc_en=0; epc<=id_pc if id_valid else if_pc; drain counter<=0; next INT_DRAIN.
REQ-010 INT_DRAIN: pc_en=0, if_id_clr_n=0, id_ex_clr_n=0 every cycle; EX/DM and DM/WB advance; drain counter increments; after 3 drain cycles next INT_VECTOR.
REQ-011 INT_VECTOR, one cycle: pc_sel=2, pc_en=1, if_id_clr_n=0, irq_ack=1; next RUN; irq_req sampled again only from the following RUN cycle.
REQ-012 wb_halt=1 in any state except HALTED SHALL win over all else: next HALTED, pending interrupt sequence abandoned, epc kept.
REQ-013 HALTED: pc_en and all *_en=0, halted=1; resume=1 returns to RUN next cycle; wb_halt ignored in HALTED.
REQ-014 stall_cnt, flush_cnt SHALL saturate at 16'hFFFF, no wrap.

Reset
REQ-015 rst_n=0 SHALL asynchronously force state RUN, drain counter 0, epc 0, stall_cnt 0, flush_cnt 0.
REQ-016 While rst_n=0, combinational outputs SHALL hold reset-state values: halted=0, irq_ack=0, pc_sel=0.
REQ-017 Reset mid-INT_DRAIN or in HALTED SHALL abandon the sequence; first post-reset cycle is RUN.

Verification
REQ-018 Load-use: ex_is_load=1, ex_rd=8, id_rs=8, id_rs_used=1 for one cycle -> pc_en=0, if_id_stall=1, id_ex_clr_n=0 that cycle; stall_cnt=1.
REQ-019 Branch + hazard together -> pc_sel=1, if_id_clr_n=0, id_ex_clr_n=0, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-020 irq_req=1, id_pc=0x40, id_valid=1 -> epc=0x40; 4 cycles with pc_en=0 (entry + 3 drain); then irq_ack=1, pc_sel=2 for one cycle.
REQ-021 wb_halt=1 in 2nd drain cycle -> HALTED next cycle, all enables 0, irq_ack never asserted; resume=1 -> RUN.
REQ-022 Hold hazard for 70000 cycles -> stall_cnt=16'hFFFF, unchanged after.
REQ-023 rst_n low mid-INT_DRAIN -> epc=0, counters 0, RUN immediately, no clock edge required.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush/interrupt/halt controller: combinational stage controls
// driven by a 4-state FSM, plus saved return PC and saturating event counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 32
`endif

module pipeline_ctrl #(
    parameter int ADDR_W = `IM_ADDR_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_en,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_branch_taken,
    input  logic              wb_halt,
    input  logic              resume,
    input  logic              irq_req,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_pc,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pc_en,
    output logic [1:0]        pc_sel,
    output logic              if_id_en,
    output logic              if_id_stall,
    output logic              if_id_clr_n,
    output logic              id_ex_en,
    output logic              id_ex_clr_n,
    output logic              ex_dm_en,
    output logic              ex_dm_clr_n,
    output logic              dm_wb_en,
    output logic              dm_wb_clr_n,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] epc,
    output logic              halted,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [1:0]        state_dbg
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] INT_DRAIN  = 2'd1;
    localparam logic [1:0] INT_VECTOR = 2'd2;
    localparam logic [1:0] HALTED     = 2'd3;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [1:0] state;
    logic [1:0] next_state;
    logic [1:0] drain_cnt;
    logic [1:0] drain_next;
    logic       epc_load;
    logic       stall_inc;
    logic       flush_inc;
    logic       hazard;

    assign state_dbg = state;

    assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

    // Outputs stay at their idle defaults while reset is held, whatever the inputs do.
    always_comb begin
        pc_en       = core_en;
        pc_sel      = 2'd0;
        if_id_en    = core_en;
        if_id_stall = 1'b0;
        if_id_clr_n = 1'b1;
        id_ex_en    = core_en;
        id_ex_clr_n = 1'b1;
        ex_dm_en    = core_en;
        ex_dm_clr_n = 1'b1;
        dm_wb_en    = core_en;
        dm_wb_clr_n = 1'b1;
        irq_ack     = 1'b0;
        halted      = 1'b0;
        next_state  = state;
        drain_next  = drain_cnt;
        epc_load    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;

        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_sel      = 2'd1;
                        if_id_clr_n = 1'b0;
                        id_ex_clr_n = 1'b0;
                        flush_inc   = 1'b1;
                    end else if (irq_req) begin
                        // Entry already bubbles ID/EX, so a pending load-use stall is moot.
                        pc_en       = 1'b0;
                        if_id_clr_n = 1'b0;
                        id_ex_clr_n = 1'b0;
                        epc_load    = 1'b1;
                        drain_next  = 2'd0;
                        next_state  = INT_DRAIN;
                    end else if (hazard) begin
                        pc_en       = 1'b0;
                        if_id_stall = 1'b1;
                        id_ex_clr_n = 1'b0;
                        stall_inc   = 1'b1;
                    end
                end
                INT_DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_clr_n = 1'b0;
                    id_ex_clr_n = 1'b0;
                    drain_next  = drain_cnt + 2'd1;
                    if (drain_cnt == 2'd2) next_state = INT_VECTOR;
                end
                INT_VECTOR: begin
                    pc_sel      = 2'd2;
                    pc_en       = core_en;
                    if_id_clr_n = 1'b0;
                    irq_ack     = 1'b1;
                    next_state  = RUN;
                end
                default: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    ex_dm_en = 1'b0;
                    dm_wb_en = 1'b0;
                    halted   = 1'b1;
                    if (resume) next_state = RUN;
                end
            endcase

            if (wb_halt && (state != HALTED)) begin
                next_state = HALTED;
                epc_load   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            epc       <= '0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else if (core_en) begin
            state     <= next_state;
            drain_cnt <= drain_next;
            if (epc_load) epc <= id_valid ? id_pc : if_pc;
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 16'd1;
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: table of single-cycle RUN vectors, random hazard
// vectors, and hand sequences for interrupt, halt, async reset and saturation.
module tb_pipeline_ctrl;

    localparam int AW = 32;

    typedef struct packed {
        logic       core_en;
        logic       ex_is_load;
        logic [4:0] ex_rd;
        logic [4:0] id_rs;
        logic       id_rs_used;
        logic [4:0] id_rt;
        logic       id_rt_used;
        logic       br;
        logic       irq;
        logic       halt;
        logic       resume;
        logic       id_valid;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [13:0] exp;
        logic        inc_stall;
        logic        inc_flush;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_en, id_rs_used, id_rt_used, ex_is_load, ex_branch_taken;
    logic          wb_halt, resume, irq_req, id_valid;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic [AW-1:0] id_pc, if_pc;
    logic          pc_en, if_id_en, if_id_stall, if_id_clr_n, id_ex_en, id_ex_clr_n;
    logic          ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n, irq_ack, halted;
    logic [1:0]    pc_sel, state_dbg;
    logic [AW-1:0] epc;
    logic [15:0]   stall_cnt, flush_cnt;

    logic [13:0] ctrl_word;
    logic [13:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    vec_t        tbl[12];
    stim_t       s;
    int          exp_stall, exp_flush;
    logic [13:0] c_idle, c_frozen, c_branch, c_stall, c_stall_off, c_drain;
    logic [13:0] c_drain_off, c_vector, c_halted;

    pipeline_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .core_en(core_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .wb_halt(wb_halt), .resume(resume), .irq_req(irq_req), .id_valid(id_valid),
        .id_pc(id_pc), .if_pc(if_pc),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_stall(if_id_stall),
        .if_id_clr_n(if_id_clr_n), .id_ex_en(id_ex_en), .id_ex_clr_n(id_ex_clr_n),
        .ex_dm_en(ex_dm_en), .ex_dm_clr_n(ex_dm_clr_n), .dm_wb_en(dm_wb_en),
        .dm_wb_clr_n(dm_wb_clr_n), .irq_ack(irq_ack), .epc(epc), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    assign ctrl_word = {pc_en, pc_sel, if_id_en, if_id_stall, if_id_clr_n, id_ex_en,
                        id_ex_clr_n, ex_dm_en, ex_dm_clr_n, dm_wb_en, dm_wb_clr_n,
                        irq_ack, halted};

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, expected test end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [13:0] ctrl(logic p_en, logic [1:0] sel, logic stall,
                                         logic ifc_n, logic idc_n, logic en,
                                         logic ack, logic hlt);
        return {p_en, sel, en, stall, ifc_n, en, idc_n, en, 1'b1, en, 1'b1, ack, hlt};
    endfunction

    function automatic stim_t mk(logic ce, logic ld, logic [4:0] rd, logic [4:0] rs,
                                 logic rsu, logic [4:0] rt, logic rtu, logic b);
        stim_t t;
        t = '0;
        t.core_en = ce; t.ex_is_load = ld; t.ex_rd = rd; t.id_rs = rs;
        t.id_rs_used = rsu; t.id_rt = rt; t.id_rt_used = rtu; t.br = b;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input stim_t t);
        core_en = t.core_en; ex_is_load = t.ex_is_load; ex_rd = t.ex_rd;
        id_rs = t.id_rs; id_rs_used = t.id_rs_used; id_rt = t.id_rt;
        id_rt_used = t.id_rt_used; ex_branch_taken = t.br; irq_req = t.irq;
        wb_halt = t.halt; resume = t.resume; id_valid = t.id_valid;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_check(input string name);
        logic [13:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, ctrl_word);
        end else begin
            e = exp_q.pop_front();
            chk(name, {18'd0, ctrl_word}, {18'd0, e});
        end
    endtask

    // Inputs are already driven (just after a rising edge); check this cycle's controls.
    task automatic step(input logic [13:0] e, input string name);
        exp_q.push_back(e);
        @(negedge clk);
        sb_check(name);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test ----------------
    initial begin
        c_idle      = ctrl(1, 2'd0, 0, 1, 1, 1, 0, 0);
        c_frozen    = ctrl(0, 2'd0, 0, 1, 1, 0, 0, 0);
        c_branch    = ctrl(1, 2'd1, 0, 0, 0, 1, 0, 0);
        c_stall     = ctrl(0, 2'd0, 1, 1, 0, 1, 0, 0);
        c_stall_off = ctrl(0, 2'd0, 1, 1, 0, 0, 0, 0);
        c_drain     = ctrl(0, 2'd0, 0, 0, 0, 1, 0, 0);
        c_drain_off = ctrl(0, 2'd0, 0, 0, 0, 0, 0, 0);
        c_vector    = ctrl(1, 2'd2, 0, 0, 1, 1, 1, 0);
        c_halted    = ctrl(0, 2'd0, 0, 1, 1, 0, 0, 1);
        id_pc = '0;
        if_pc = '0;

        // Reset held with branch, hazard and irq all active: outputs must stay idle.
        rst_n = 1'b0;
        s = mk(1, 1, 8, 8, 1, 0, 0, 1);
        s.irq = 1'b1;
        apply(s);
        repeat (2) @(posedge clk);
        exp_q.push_back(c_idle);
        @(negedge clk);
        sb_check("reset_ctrl");
        chk("reset_state", {30'd0, state_dbg}, 32'd0);
        chk("reset_epc", epc, 32'd0);
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single load-use hazard.
        apply(mk(1, 1, 8, 8, 1, 0, 0, 0));
        step(c_stall, "load_use");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(c_idle, "after_load_use");
        chk("load_use_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        chk("load_use_flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // Branch wins over hazard.
        do_reset();
        apply(mk(1, 1, 8, 8, 1, 0, 0, 1));
        step(c_branch, "branch_hazard");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        step(c_idle, "after_branch");
        chk("branch_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("branch_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Table of single-cycle RUN vectors.
        do_reset();
        tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0), c_idle,      0, 0};
        tbl[1]  = '{mk(1, 1, 8, 8, 1, 3, 1, 0), c_stall,     1, 0};
        tbl[2]  = '{mk(1, 1, 8, 8, 0, 3, 1, 0), c_idle,      0, 0};
        tbl[3]  = '{mk(1, 1, 9, 2, 1, 9, 1, 0), c_stall,     1, 0};
        tbl[4]  = '{mk(1, 1, 0, 0, 1, 0, 1, 0), c_idle,      0, 0};
        tbl[5]  = '{mk(1, 0, 8, 8, 1, 8, 1, 0), c_idle,      0, 0};
        tbl[6]  = '{mk(1, 1, 8, 7, 1, 6, 1, 0), c_idle,      0, 0};
        tbl[7]  = '{mk(1, 1, 5, 5, 1, 5, 1, 1), c_branch,    0, 1};
        tbl[8]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1), c_branch,    0, 1};
        tbl[9]  = '{mk(0, 1, 8, 8, 1, 0, 0, 0), c_stall_off, 0, 0};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0), c_frozen,    0, 0};
        tbl[11] = '{mk(1, 1, 31, 4, 0, 31, 1, 0), c_stall,   1, 0};
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].s);
            step(tbl[i].exp, $sformatf("tbl%0d", i));
            if (tbl[i].inc_stall) exp_stall++;
            if (tbl[i].inc_flush) exp_flush++;
        end

        // Random hazard vectors; small register range to force collisions.
        for (int i = 0; i < 40; i++) begin
            logic hz;
            s = mk(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
            hz = s.ex_is_load && (s.ex_rd != 0) &&
                 ((s.id_rs_used && s.id_rs == s.ex_rd) || (s.id_rt_used && s.id_rt == s.ex_rd));
            apply(s);
            step(hz ? c_stall : c_idle, $sformatf("rand%0d", i));
            if (hz) exp_stall++;
        end
        chk("table_stall_cnt", {16'd0, stall_cnt}, 32'(exp_stall));
        chk("table_flush_cnt", {16'd0, flush_cnt}, 32'(exp_flush));

        // Interrupt: entry + 3 drain, vector, immediate re-entry with irq still high.
        s = mk(1, 0, 0, 0, 0, 0, 0, 0);
        s.irq = 1'b1; s.id_valid = 1'b1;
        id_pc = 32'h40; if_pc = 32'h44;
        apply(s);
        step(c_drain, "irq_entry");
        chk("irq_epc", epc, 32'h40);
        chk("irq_state_drain", {30'd0, state_dbg}, 32'd1);
        step(c_drain, "drain0");
        step(c_drain, "drain1");
        step(c_drain, "drain2");
        step(c_vector, "vector");
        chk("vector_state_run", {30'd0, state_dbg}, 32'd0);
        s.id_valid = 1'b0;
        apply(s);
        step(c_drain, "irq_reentry");
        chk("reentry_epc_ifpc", epc, 32'h44);
        s.irq = 1'b0;
        apply(s);
        step(c_drain, "re_drain0");
        s.core_en = 1'b0;
        apply(s);
        step(c_drain_off, "re_drain_frozen");
        s.core_en = 1'b1;
        apply(s);
        step(c_drain, "re_drain1");
        step(c_drain, "re_drain2");
        step(c_vector, "re_vector");
        step(c_idle, "re_run");

        // Halt in the second drain cycle.
        s = mk(1, 0, 0, 0, 0, 0, 0, 0);
        s.irq = 1'b1; s.id_valid = 1'b1;
        id_pc = 32'h80;
        apply(s);
        step(c_drain, "halt_irq_entry");
        chk("halt_irq_epc", epc, 32'h80);
        step(c_drain, "halt_drain0");
        s.halt = 1'b1;
        apply(s);
        step(c_drain, "halt_drain1");
        chk("halt_state", {30'd0, state_dbg}, 32'd3);
        step(c_halted, "halted0");
        step(c_halted, "halted1");
        chk("halt_epc_kept", epc, 32'h80);
        s.halt = 1'b0; s.irq = 1'b0; s.resume = 1'b1;
        apply(s);
        step(c_halted, "halted_resume");
        chk("resume_state_run", {30'd0, state_dbg}, 32'd0);
        s.resume = 1'b0;
        apply(s);
        step(c_idle, "after_resume");

        // Asynchronous reset in the middle of a drain.
        s = mk(1, 0, 0, 0, 0, 0, 0, 0);
        s.irq = 1'b1; s.id_valid = 1'b1;
        id_pc = 32'h90;
        apply(s);
        step(c_drain, "arst_irq_entry");
        step(c_drain, "arst_drain0");
        chk("arst_epc_before", epc, 32'h90);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", {30'd0, state_dbg}, 32'd0);
        chk("arst_epc", epc, 32'd0);
        chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("arst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        exp_q.push_back(c_idle);
        sb_check("arst_ctrl");
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(c_idle, "arst_first_run");

        // Stall counter saturation.
        apply(mk(1, 1, 8, 8, 1, 0, 0, 0));
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (5) @(posedge clk);
        #1;
        step(c_stall, "sat_still_stalling");
        chk("stall_saturated_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
